// File: rtl/serial_addsub_ctrl.sv
// ============================================================================
//  Module      : serial_addsub_ctrl
//  Description : Bit-serial add/subtract sequencer. One full adder/subtractor
//                cell is reused LSB-first over WIDTH cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_addsub_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              mode_q, mode_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;

    logic              w_a_bit;
    logic              w_b_bit;
    logic              w_sum_bit;
    logic              w_carry_nxt;

    // The single shared cell; subtraction differs only in the borrow term.
    always_comb begin
        w_a_bit   = a_q[cnt_q];
        w_b_bit   = b_q[cnt_q];
        w_sum_bit = w_a_bit ^ w_b_bit ^ carry_q;
        if (mode_q) begin
            w_carry_nxt = (~w_a_bit & w_b_bit) | (carry_q & ~(w_a_bit ^ w_b_bit));
        end else begin
            w_carry_nxt = (w_a_bit & w_b_bit) | (carry_q & (w_a_bit ^ w_b_bit));
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        mode_d   = mode_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d      = a;
                    b_d      = b;
                    mode_d   = mode;
                    carry_d  = cin;
                    cnt_d    = '0;
                    result_d = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                result_d[cnt_q] = w_sum_bit;
                carry_d         = w_carry_nxt;
                cnt_d           = cnt_q + CNT_W'(1);
                if (cnt_q == C_LAST_BIT) begin
                    // The MSB being written this cycle is the final result MSB.
                    cout_d = w_carry_nxt;
                    if (mode_q) begin
                        ovf_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (w_sum_bit != a_q[WIDTH-1]);
                    end else begin
                        ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (w_sum_bit != a_q[WIDTH-1]);
                    end
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            mode_q   <= 1'b0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            mode_q   <= mode_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_addsub_ctrl.sv
// ============================================================================
//  Module      : tb_serial_addsub_ctrl
//  Description : Self-checking bench for serial_addsub_ctrl, directed + random.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_addsub_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         mode;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;

    int n_checks;
    int n_fail;

    serial_addsub_ctrl #(.WIDTH(W)) u_dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .mode   (mode),
        .cin    (cin),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Arithmetic reference: plain integer add/sub, signed range test for overflow.
    task automatic model(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tm,
                         input logic tc, output logic [W-1:0] r, output logic co,
                         output logic ov);
        int ua, ub, sa, sb, u, s;
        ua = int'(ta);
        ub = int'(tb);
        sa = int'($signed(ta));
        sb = int'($signed(tb));
        if (!tm) begin
            u  = ua + ub + int'(tc);
            s  = sa + sb + int'(tc);
            co = (u > (1 << W) - 1);
        end else begin
            u  = ua - ub - int'(tc);
            s  = sa - sb - int'(tc);
            co = (u < 0);
        end
        r  = u[W-1:0];
        ov = (s > (1 << (W - 1)) - 1) || (s < -(1 << (W - 1)));
    endtask

    // One full operation; disturb_cyc > 0 re-drives start with junk inputs mid-RUN.
    task automatic do_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic tm, input logic tc, input int disturb_cyc);
        logic [W-1:0] er;
        logic         eco, eov;
        logic         busy_ok;
        model(ta, tb, tm, tc, er, eco, eov);
        @(negedge clk);
        a = ta; b = tb; mode = tm; cin = tc; start = 1'b1;
        @(posedge clk);
        busy_ok = 1'b1;
        for (int k = 1; k <= W; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (disturb_cyc > 0 && k == disturb_cyc) begin
                start = 1'b1; a = 8'hFF; b = ~tb; mode = ~tm; cin = ~tc;
            end
            if (disturb_cyc > 0 && k == disturb_cyc + 1) start = 1'b0;
            if (busy !== 1'b1 || done !== 1'b0) busy_ok = 1'b0;
        end
        check({tag, "_busy_window"}, 32'(busy_ok), 32'd1);
        @(negedge clk);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
        check({tag, "_result"}, 32'(result), 32'(er));
        check({tag, "_cout"}, 32'(cout), 32'(eco));
        check({tag, "_ovf"}, 32'(ovf), 32'(eov));
        @(negedge clk);
        check({tag, "_done_drop"}, 32'(done), 32'd0);
        check({tag, "_hold"}, {23'd0, ovf, cout, result}, {23'd0, eov, eco, er});
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic         rm, rc, seen;
        int           first_n;
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; mode = 1'b0; cin = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_outs", {27'd0, busy, done, cout, ovf, |result}, 32'd0);

        do_op("add_35_4a", 8'h35, 8'h4A, 1'b0, 1'b0, 0);
        do_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 0);
        do_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 0);
        do_op("add_cin",   8'h10, 8'h20, 1'b0, 1'b1, 0);
        do_op("sub_05_07", 8'h05, 8'h07, 1'b1, 1'b0, 0);
        do_op("sub_80_01", 8'h80, 8'h01, 1'b1, 1'b0, 0);
        do_op("sub_07_07", 8'h07, 8'h07, 1'b1, 1'b1, 0);
        do_op("ignore_start", 8'h35, 8'h4A, 1'b0, 1'b0, 3);
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("no_second_done", 32'(seen), 32'd0);

        // Abort mid-RUN: rst during the 4th RUN cycle.
        @(negedge clk);
        a = 8'h35; b = 8'h4A; mode = 1'b0; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_outs", {23'd0, busy, done, cout, ovf, 1'b0, result[3:0]}, 32'd0);
        check("abort_result", 32'(result), 32'd0);
        seen = 1'b0;
        repeat (W + 2) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        check("abort_no_done", 32'(seen), 32'd0);
        do_op("post_abort", 8'h01, 8'h01, 1'b0, 1'b0, 0);

        // start held across two back-to-back operations.
        @(negedge clk);
        a = 8'h01; b = 8'h02; mode = 1'b0; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        repeat (W + 1) @(negedge clk);
        check("hold_first_done", 32'(done), 32'd1);
        check("hold_first_result", 32'(result), 32'h03);
        a = 8'h03; b = 8'h04;
        first_n = -1;
        for (int n = 1; n <= 2 * W + 4; n++) begin
            @(negedge clk);
            if (n == 2) start = 1'b0;
            if (done && first_n < 0) begin
                first_n = n;
                check("hold_second_result", 32'(result), 32'h07);
            end
        end
        check("hold_spacing", 32'(first_n), 32'(W + 2));

        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rm = 1'($urandom);
            rc = 1'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_op($sformatf("rnd%0d", i), ra, rb, rm, rc, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
